// File: rtl/i2c_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : i2c_wb_queue
// Purpose  : Posted-write queue between a host Wishbone port and an I2C bus
//            controller Wishbone port. Host writes to QUEUE_ADDR are acked
//            immediately and buffered in a small FIFO. A master FSM replays
//            them one at a time to the controller, with a one-cycle GAP state
//            after every completed transfer.
// Ports    : clk, rst_n (synchronous, active low)
//            s_*   : host-side Wishbone slave (write-only queue address)
//            m_*   : controller-side Wishbone master
//            full_o, empty_o, level_o : FIFO status
//            drop_o: one-cycle pulse in the ack cycle of a discarded write
//            drop_cnt_o : saturating dropped-write count (optional)
// Options  : define I2C_QUEUE_DROP_CNT_EN to add drop_cnt_o and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_wb_queue #(
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       WB_ADDR_WIDTH = 6,
    parameter logic [WB_ADDR_WIDTH-1:0] QUEUE_ADDR    = 6'h3d,
    parameter int                       DEPTH_LOG2    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // Host side
    input  logic [WB_ADDR_WIDTH-1:0] s_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] s_dat_i,
    input  logic                     s_we_i,
    input  logic                     s_stb_i,
    input  logic                     s_cyc_i,
    output logic                     s_ack_o,
    // Controller side
    output logic [WB_ADDR_WIDTH-1:0] m_adr_o,
    output logic [WB_DATA_WIDTH-1:0] m_dat_o,
    output logic                     m_we_o,
    output logic                     m_stb_o,
    output logic                     m_cyc_o,
    input  logic                     m_ack_i,
    // Status
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DEPTH_LOG2:0]      level_o,
    output logic                     drop_o
`ifdef I2C_QUEUE_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt_o
`endif
);

    localparam int                  c_entry_w    = WB_ADDR_WIDTH + WB_DATA_WIDTH;
    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_level = (DEPTH_LOG2+1)'(c_depth);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_entry_w-1:0]   r_mem [c_depth];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_ack;
    logic                   r_drop;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [c_entry_w-1:0]   w_head;

    // Full/empty come from the registered count, so a pop in the same cycle
    // cannot rescue a write that arrives while the FIFO is full.
    assign w_full  = (r_level == c_full_level);
    assign w_empty = (r_level == '0);

    // r_ack blocks a second accept of the same (still asserted) strobe in the
    // ack cycle.
    assign w_accept = s_we_i & s_stb_i & s_cyc_i & (s_adr_i == QUEUE_ADDR) & ~r_ack;
    assign w_push   = w_accept & ~w_full;
    // REQ is only entered with a non-empty FIFO and nothing else pops, so a
    // pop can never underflow.
    assign w_pop    = (r_state == S_REQ) & m_ack_i;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= {s_adr_i, s_dat_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (DEPTH_LOG2+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (DEPTH_LOG2+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Host acknowledge and drop pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_drop <= w_accept & w_full;
        end
    end

    // ------------------------------------------------------------------------
    // Master FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        m_stb_o      = 1'b0;
        m_cyc_o      = 1'b0;
        m_we_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                m_stb_o = 1'b1;
                m_cyc_o = 1'b1;
                m_we_o  = 1'b1;
                if (m_ack_i) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The head entry is visible whenever the FIFO holds data; it only changes
    // on a pop, so it stays stable for the whole REQ phase.
    assign w_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign m_adr_o = w_head[c_entry_w-1 -: WB_ADDR_WIDTH];
    assign m_dat_o = w_head[WB_DATA_WIDTH-1:0];

    assign s_ack_o = r_ack;
    assign drop_o  = r_drop;
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign level_o = r_level;

`ifdef I2C_QUEUE_DROP_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating dropped-write counter
    // ------------------------------------------------------------------------
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_full && (r_drop_cnt != 8'hff)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule
`default_nettype wire
